vx_scoreboard_gate: RTL and testbench

Per-issue-slice register scoreboard between the instruction buffer and the operand-fetch stage. It tracks outstanding GPR writes per warp and holds an instruction back while any source or destination register has a write in flight. Each instruction that passes is registered into a one-entry output stage toward operand fetch. Writeback traffic, the same stream the operand stage uses to update its register file, clears pending entries.

---
 rtl/VX_gpu_pkg.sv | 45 ++++
 rtl/vx_scoreboard_gate_if.sv | 40 ++++
 rtl/vx_scoreboard_wb_if.sv | 22 ++
 rtl/VX_elastic_buffer.sv | 36 +++
 rtl/vx_scoreboard_table.sv | 55 +++++
 rtl/vx_scoreboard_gate.sv | 145 ++++++++++++++
 tb/tb_vx_scoreboard_gate.sv | 256 +++++++++++++++++++++++++
 7 files changed

// File: rtl/VX_gpu_pkg.sv
// Shared GPU core types and sizing helpers.
package VX_gpu_pkg;
  localparam int NUM_REGS    = 32;
  localparam int NR_BITS     = 5;
  localparam int NUM_THREADS = 4;
  localparam int XLEN        = 32;
  localparam int UUID_W      = 16;
  localparam int PC_W        = 32;
  localparam int EX_W        = 3;
  localparam int OP_TYPE_W   = 4;
  localparam int OP_MOD_W    = 3;
  localparam int IMM_W       = 32;

  function automatic int issue_ratio(
    input int warps,
    input int issue
  );
    return warps / issue;
  endfunction

  function automatic int issue_wis_w(
    input int warps,
    input int issue
  );
    return (warps / issue > 1) ?
      $clog2(warps / issue) : 1;
  endfunction

  typedef struct packed {
    logic [UUID_W-1:0]      uuid;
    logic [NUM_THREADS-1:0] tmask;
    logic [PC_W-1:0]        PC;
    logic [EX_W-1:0]        ex_type;
    logic [OP_TYPE_W-1:0]   op_type;
    logic [OP_MOD_W-1:0]    op_mod;
    logic                   wb;
    logic                   use_PC;
    logic                   use_imm;
    logic [IMM_W-1:0]       imm;
    logic [NR_BITS-1:0]     rd;
    logic [NR_BITS-1:0]     rs1;
    logic [NR_BITS-1:0]     rs2;
    logic [NR_BITS-1:0]     rs3;
  } inst_t;
endpackage

// File: rtl/vx_scoreboard_gate_if.sv
// Decoded-instruction valid/ready bus.
interface vx_scoreboard_gate_if #(
  parameter int WIS_W = 1
);
  import VX_gpu_pkg::*;

  logic                   valid;
  logic                   ready;
  logic [UUID_W-1:0]      uuid;
  logic [WIS_W-1:0]       wis;
  logic [NUM_THREADS-1:0] tmask;
  logic [PC_W-1:0]        PC;
  logic [EX_W-1:0]        ex_type;
  logic [OP_TYPE_W-1:0]   op_type;
  logic [OP_MOD_W-1:0]    op_mod;
  logic                   wb;
  logic                   use_PC;
  logic                   use_imm;
  logic [IMM_W-1:0]       imm;
  logic [NR_BITS-1:0]     rd;
  logic [NR_BITS-1:0]     rs1;
  logic [NR_BITS-1:0]     rs2;
  logic [NR_BITS-1:0]     rs3;

  modport master (
    output valid, uuid, wis, tmask, PC,
    output ex_type, op_type, op_mod, wb,
    output use_PC, use_imm, imm,
    output rd, rs1, rs2, rs3,
    input  ready
  );

  modport slave (
    input  valid, uuid, wis, tmask, PC,
    input  ex_type, op_type, op_mod, wb,
    input  use_PC, use_imm, imm,
    input  rd, rs1, rs2, rs3,
    output ready
  );
endinterface

// File: rtl/vx_scoreboard_wb_if.sv
// Register-file writeback stream.
interface vx_scoreboard_wb_if #(
  parameter int WIS_W = 1
);
  import VX_gpu_pkg::*;

  logic                        valid;
  logic [WIS_W-1:0]            wis;
  logic [NR_BITS-1:0]          rd;
  logic [NUM_THREADS-1:0]      tmask;
  logic [NUM_THREADS*XLEN-1:0] data;
  logic                        sop;
  logic                        eop;

  modport master (
    output valid, wis, rd, tmask, data, sop, eop
  );

  modport slave (
    input valid, wis, rd, tmask, data, sop, eop
  );
endinterface

// File: rtl/VX_elastic_buffer.sv
// Single-entry elastic buffer with registered output.
module VX_elastic_buffer #(
  parameter int DATAW   = 1,
  parameter int SIZE    = 1,
  parameter int OUT_REG = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  output logic [DATAW-1:0] data_out,
  input  logic             ready_out,
  output logic             valid_out
);
  localparam int unused_cfg = SIZE + OUT_REG;

  logic             r_valid;
  logic [DATAW-1:0] r_data;

  // a full entry can be replaced while it drains
  assign ready_in  = ~r_valid | ready_out;
  assign valid_out = r_valid;
  assign data_out  = r_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else begin
      if (ready_in)
        r_valid <= valid_in;
      if (valid_in && ready_in)
        r_data <= data_in;
    end
  end
endmodule

// File: rtl/vx_scoreboard_table.sv
// Per-warp pending-write bits with set/clear and 4 read ports.
module vx_scoreboard_table
  import VX_gpu_pkg::*;
#(
  parameter int RATIO = 1,
  parameter int WIS_W = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_set,
  input  logic [WIS_W-1:0]   i_set_wis,
  input  logic [NR_BITS-1:0] i_set_rd,
  input  logic               i_clr,
  input  logic [WIS_W-1:0]   i_clr_wis,
  input  logic [NR_BITS-1:0] i_clr_rd,
  input  logic [WIS_W-1:0]   i_wis,
  input  logic [NR_BITS-1:0] i_rs1,
  input  logic [NR_BITS-1:0] i_rs2,
  input  logic [NR_BITS-1:0] i_rs3,
  input  logic [NR_BITS-1:0] i_rd,
  output logic               o_rs1,
  output logic               o_rs2,
  output logic               o_rs3,
  output logic               o_rd
);
  logic [NUM_REGS-1:0] r_pending [RATIO];
  logic [NUM_REGS-1:0] w_row;

  // r0 is never pending
  assign w_row = r_pending[i_wis];
  assign o_rs1 = (i_rs1 != '0) && w_row[i_rs1];
  assign o_rs2 = (i_rs2 != '0) && w_row[i_rs2];
  assign o_rs3 = (i_rs3 != '0) && w_row[i_rs3];
  assign o_rd  = (i_rd  != '0) && w_row[i_rd];

  // set is applied last so it wins a collision
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < RATIO; w++)
        r_pending[w] <= '0;
    end else begin
      if (i_clr)
        r_pending[i_clr_wis][i_clr_rd] <= 1'b0;
      if (i_set)
        r_pending[i_set_wis][i_set_rd] <= 1'b1;
    end
  end

  a_set_clr: assert property (
    @(posedge clk) disable iff (reset)
    !(i_set && i_clr &&
      i_set_wis == i_clr_wis &&
      i_set_rd == i_clr_rd)
  );
endmodule

// File: rtl/vx_scoreboard_gate.sv
// Register scoreboard gating ibuffer -> operand fetch per slice.
module vx_scoreboard_gate
  import VX_gpu_pkg::*;
#(
  parameter int CORE_ID       = 0,
  parameter int ISSUE_CNT     = 1,
  parameter int WARP_CNT      = 4,
  parameter int STALL_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  reset,
  vx_scoreboard_gate_if.slave   ibuffer_if    [ISSUE_CNT],
  vx_scoreboard_wb_if.slave     writeback_if  [ISSUE_CNT],
  vx_scoreboard_gate_if.master  scoreboard_if [ISSUE_CNT],
  output logic [ISSUE_CNT-1:0]  stall_timeout
);
  localparam int RATIO = issue_ratio(WARP_CNT, ISSUE_CNT);
  localparam int WIS_W = issue_wis_w(WARP_CNT, ISSUE_CNT);
  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
  localparam int DW    = WIS_W + $bits(inst_t);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(STALL_TIMEOUT);
  localparam int unused_core = CORE_ID;

  for (genvar s = 0; s < ISSUE_CNT; s++) begin : g_slice
    inst_t            w_in;
    inst_t            w_out;
    logic [WIS_W-1:0] w_out_wis;
    logic [DW-1:0]    w_buf_out;
    logic             w_out_ready_in;
    logic             w_p_rs1, w_p_rs2, w_p_rs3, w_p_rd;
    logic             w_hazard;
    logic             w_ready;
    logic             w_fire;
    logic             w_unused_wb;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flag;

    assign w_in = '{
      uuid:    ibuffer_if[s].uuid,
      tmask:   ibuffer_if[s].tmask,
      PC:      ibuffer_if[s].PC,
      ex_type: ibuffer_if[s].ex_type,
      op_type: ibuffer_if[s].op_type,
      op_mod:  ibuffer_if[s].op_mod,
      wb:      ibuffer_if[s].wb,
      use_PC:  ibuffer_if[s].use_PC,
      use_imm: ibuffer_if[s].use_imm,
      imm:     ibuffer_if[s].imm,
      rd:      ibuffer_if[s].rd,
      rs1:     ibuffer_if[s].rs1,
      rs2:     ibuffer_if[s].rs2,
      rs3:     ibuffer_if[s].rs3
    };

    assign w_unused_wb = ^{writeback_if[s].sop,
                           writeback_if[s].tmask,
                           writeback_if[s].data};

    vx_scoreboard_table #(
      .RATIO (RATIO),
      .WIS_W (WIS_W)
    ) u_table (
      .clk       (clk),
      .reset     (reset),
      .i_set     (w_fire && w_in.wb && w_in.rd != '0),
      .i_set_wis (ibuffer_if[s].wis),
      .i_set_rd  (w_in.rd),
      .i_clr     (writeback_if[s].valid &&
                  writeback_if[s].eop),
      .i_clr_wis (writeback_if[s].wis),
      .i_clr_rd  (writeback_if[s].rd),
      .i_wis     (ibuffer_if[s].wis),
      .i_rs1     (w_in.rs1),
      .i_rs2     (w_in.rs2),
      .i_rs3     (w_in.rs3),
      .i_rd      (w_in.rd),
      .o_rs1     (w_p_rs1),
      .o_rs2     (w_p_rs2),
      .o_rs3     (w_p_rs3),
      .o_rd      (w_p_rd)
    );

    assign w_hazard = w_p_rs1 | w_p_rs2 | w_p_rs3 |
                      (w_in.wb & w_p_rd);
    assign w_ready  = ~w_hazard & w_out_ready_in;
    assign w_fire   = ibuffer_if[s].valid & w_ready;
    assign ibuffer_if[s].ready = w_ready;

    VX_elastic_buffer #(
      .DATAW   (DW),
      .SIZE    (1),
      .OUT_REG (1)
    ) u_out (
      .clk       (clk),
      .reset     (reset),
      .valid_in  (ibuffer_if[s].valid && !w_hazard),
      .ready_in  (w_out_ready_in),
      .data_in   ({ibuffer_if[s].wis, w_in}),
      .data_out  (w_buf_out),
      .ready_out (scoreboard_if[s].ready),
      .valid_out (scoreboard_if[s].valid)
    );

    assign {w_out_wis, w_out} = w_buf_out;
    assign scoreboard_if[s].wis     = w_out_wis;
    assign scoreboard_if[s].uuid    = w_out.uuid;
    assign scoreboard_if[s].tmask   = w_out.tmask;
    assign scoreboard_if[s].PC      = w_out.PC;
    assign scoreboard_if[s].ex_type = w_out.ex_type;
    assign scoreboard_if[s].op_type = w_out.op_type;
    assign scoreboard_if[s].op_mod  = w_out.op_mod;
    assign scoreboard_if[s].wb      = w_out.wb;
    assign scoreboard_if[s].use_PC  = w_out.use_PC;
    assign scoreboard_if[s].use_imm = w_out.use_imm;
    assign scoreboard_if[s].imm     = w_out.imm;
    assign scoreboard_if[s].rd      = w_out.rd;
    assign scoreboard_if[s].rs1     = w_out.rs1;
    assign scoreboard_if[s].rs2     = w_out.rs2;
    assign scoreboard_if[s].rs3     = w_out.rs3;

    // blocked-cycle watchdog, saturating
    always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_fire || !ibuffer_if[s].valid)
        w_cnt_nxt = '0;
      else if (w_hazard && r_cnt != CNT_MAX)
        w_cnt_nxt = r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt  <= '0;
        r_flag <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        if (w_cnt_nxt >= TMO)
          r_flag <= 1'b1;
      end
    end

    assign stall_timeout[s] = r_flag;
  end
endmodule

// File: tb/tb_vx_scoreboard_gate.sv
// Directed vector bench for vx_scoreboard_gate.
module tb_vx_scoreboard_gate;
  logic       clk = 1'b0;
  logic       reset;
  logic [0:0] stall;
  int         n_pass = 0;
  int         n_tot  = 0;

  always #5 clk = ~clk;

  vx_scoreboard_gate_if #(.WIS_W(1)) ib_if [1] ();
  vx_scoreboard_gate_if #(.WIS_W(1)) sb_if [1] ();
  vx_scoreboard_wb_if   #(.WIS_W(1)) wb_if [1] ();

  vx_scoreboard_gate #(
    .CORE_ID       (0),
    .ISSUE_CNT     (1),
    .WARP_CNT      (2),
    .STALL_TIMEOUT (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ibuffer_if    (ib_if),
    .writeback_if  (wb_if),
    .scoreboard_if (sb_if),
    .stall_timeout (stall)
  );

  typedef struct {
    logic       v;
    logic       wis;
    logic [4:0] rd, rs1, rs2, rs3;
    logic       wb;
    logic       wv;
    logic       wwis;
    logic [4:0] wrd;
    logic       weop;
    logic       erdy;
    logic       eov;
    int         esrc;
  } vec_t;

  vec_t tab [40];

  function automatic vec_t mk(
    input int v, wis, rd, rs1, rs2, rs3, wb,
    input int wv, wwis, wrd, weop,
    input int erdy, eov, esrc
  );
    vec_t t;
    t.v = v[0]; t.wis = wis[0];
    t.rd = rd[4:0]; t.rs1 = rs1[4:0];
    t.rs2 = rs2[4:0]; t.rs3 = rs3[4:0];
    t.wb = wb[0]; t.wv = wv[0];
    t.wwis = wwis[0]; t.wrd = wrd[4:0];
    t.weop = weop[0]; t.erdy = erdy[0];
    t.eov = eov[0]; t.esrc = esrc;
    return t;
  endfunction

  task automatic chk(
    input string       nm,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, got, exp);
  endtask

  task automatic drive(
    input int v, uuid, wis, rd, rs1, rs2, rs3, wb,
    input int sbr, wv, wwis, wrd, weop
  );
    ib_if[0].valid   = v[0];
    ib_if[0].uuid    = uuid[15:0];
    ib_if[0].wis     = wis[0];
    ib_if[0].tmask   = 4'hF;
    ib_if[0].PC      = 32'h1000 + 32'(uuid * 4);
    ib_if[0].ex_type = '0;
    ib_if[0].op_type = '0;
    ib_if[0].op_mod  = '0;
    ib_if[0].wb      = wb[0];
    ib_if[0].use_PC  = 1'b0;
    ib_if[0].use_imm = 1'b0;
    ib_if[0].imm     = '0;
    ib_if[0].rd      = rd[4:0];
    ib_if[0].rs1     = rs1[4:0];
    ib_if[0].rs2     = rs2[4:0];
    ib_if[0].rs3     = rs3[4:0];
    sb_if[0].ready   = sbr[0];
    wb_if[0].valid   = wv[0];
    wb_if[0].wis     = wwis[0];
    wb_if[0].rd      = wrd[4:0];
    wb_if[0].tmask   = 4'hF;
    wb_if[0].data    = '0;
    wb_if[0].sop     = wv[0];
    wb_if[0].eop     = weop[0];
  endtask

  task automatic idle();
    drive(0,0,0,0,0,0,0,0, 1,0,0,0,0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      tab[i] = mk(1,0,i+1,0,0,0,1, 0,0,0,0,
                  1, (i > 0) ? 1 : 0, i-1);
    tab[8]  = mk(1,0,0,1,0,0,0, 0,0,0,0, 0,1,7);
    tab[9]  = mk(1,0,0,8,0,0,0, 0,0,0,0, 0,0,0);
    for (int i = 10; i < 18; i++)
      tab[i] = mk(0,0,0,0,0,0,0, 1,0,i-9,1, 1,0,0);
    tab[18] = mk(1,0,5,0,0,0,1, 0,0,0,0, 1,0,0);
    tab[19] = mk(1,0,9,0,5,0,1, 0,0,0,0, 0,1,18);
    tab[20] = mk(1,0,9,0,5,0,1, 0,0,0,0, 0,0,0);
    tab[21] = mk(1,0,9,0,5,0,1, 1,0,5,1, 0,0,0);
    tab[22] = mk(1,0,9,0,5,0,1, 0,0,0,0, 1,0,0);
    tab[23] = mk(0,0,0,0,0,0,0, 1,0,9,1, 1,1,22);
    tab[24] = mk(1,0,7,0,0,0,1, 0,0,0,0, 1,0,0);
    tab[25] = mk(1,0,0,7,0,0,0, 0,0,0,0, 0,1,24);
    tab[26] = mk(1,0,0,7,0,0,0, 1,0,7,0, 0,0,0);
    tab[27] = mk(1,0,0,7,0,0,0, 1,0,7,1, 0,0,0);
    tab[28] = mk(1,0,0,7,0,0,0, 0,0,0,0, 1,0,0);
    tab[29] = mk(0,0,0,0,0,0,0, 0,0,0,0, 1,1,28);
    tab[30] = mk(1,1,3,0,0,0,1, 0,0,0,0, 1,0,0);
    tab[31] = mk(1,0,4,3,0,0,1, 0,0,0,0, 1,1,30);
    tab[32] = mk(1,0,0,0,0,0,1, 0,0,0,0, 1,1,31);
    tab[33] = mk(1,1,0,0,0,3,0, 1,0,3,1, 0,1,32);
    tab[34] = mk(1,1,0,0,0,3,0, 1,1,3,1, 0,0,0);
    tab[35] = mk(1,1,6,0,0,3,1, 1,0,4,1, 1,0,0);
    tab[36] = mk(1,0,0,4,0,0,0, 0,0,0,0, 1,1,35);
    tab[37] = mk(1,1,0,6,0,0,0, 0,0,0,0, 0,1,36);
    tab[38] = mk(0,0,0,0,0,0,0, 1,1,6,1, 1,0,0);
    tab[39] = mk(1,1,0,6,0,0,0, 0,0,0,0, 1,0,0);

    reset = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_out_valid", sb_if[0].valid, 0);
    chk("rst_stall", stall, 0);
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 40; i++) begin
      drive(tab[i].v, i, tab[i].wis, tab[i].rd,
            tab[i].rs1, tab[i].rs2, tab[i].rs3,
            tab[i].wb, 1, tab[i].wv, tab[i].wwis,
            tab[i].wrd, tab[i].weop);
      @(negedge clk);
      chk($sformatf("ready r%0d", i),
          ib_if[0].ready, tab[i].erdy);
      chk($sformatf("out_valid r%0d", i),
          sb_if[0].valid, tab[i].eov);
      if (tab[i].eov) begin
        chk($sformatf("out_uuid r%0d", i),
            sb_if[0].uuid, tab[i].esrc);
        chk($sformatf("out_rd r%0d", i),
            sb_if[0].rd, tab[tab[i].esrc].rd);
        chk($sformatf("out_wis r%0d", i),
            sb_if[0].wis, tab[tab[i].esrc].wis);
      end
      tick();
    end

    // back-pressure: one held output, no premature set
    idle();
    tick();
    drive(1,100,0,10,0,0,0,1, 0,0,0,0,0);
    @(negedge clk);
    chk("bp_accept", ib_if[0].ready, 1);
    tick();
    for (int k = 1; k <= 5; k++) begin
      drive(1,101,0,11,0,0,0,1, 0,(k == 1) ? 1 : 0,0,10,1);
      @(negedge clk);
      chk($sformatf("bp_ready c%0d", k), ib_if[0].ready, 0);
      chk($sformatf("bp_valid c%0d", k), sb_if[0].valid, 1);
      chk($sformatf("bp_uuid c%0d", k), sb_if[0].uuid, 100);
      chk($sformatf("bp_pc c%0d", k), sb_if[0].PC, 32'h1190);
      tick();
    end
    drive(1,103,0,0,11,0,0,0, 1,0,0,0,0);
    @(negedge clk);
    chk("bp_noset_rdy", ib_if[0].ready, 1);
    chk("bp_drain_uuid", sb_if[0].uuid, 100);
    tick();
    drive(1,104,0,12,0,0,0,1, 1,0,0,0,0);
    @(negedge clk);
    chk("bp_next_rdy", ib_if[0].ready, 1);
    chk("bp_next_uuid", sb_if[0].uuid, 103);
    tick();
    drive(0,0,0,0,0,0,0,0, 1,1,0,12,1);
    @(negedge clk);
    chk("bp_last_uuid", sb_if[0].uuid, 104);
    tick();

    // watchdog on a held RAW hazard
    drive(1,200,0,2,0,0,0,1, 1,0,0,0,0);
    @(negedge clk);
    chk("wd_prod_rdy", ib_if[0].ready, 1);
    tick();
    for (int j = 1; j <= 17; j++) begin
      drive(1,201,0,0,2,0,0,0, 1,(j == 17) ? 1 : 0,0,2,1);
      @(negedge clk);
      chk($sformatf("wd_flag c%0d", j), stall, (j == 17) ? 1 : 0);
      chk($sformatf("wd_rdy c%0d", j), ib_if[0].ready, 0);
      tick();
    end
    drive(1,201,0,0,2,0,0,0, 1,0,0,0,0);
    @(negedge clk);
    chk("wd_release_rdy", ib_if[0].ready, 1);
    chk("wd_sticky0", stall, 1);
    tick();
    idle();
    @(negedge clk);
    chk("wd_sticky1", stall, 1);
    chk("wd_out_uuid", sb_if[0].uuid, 201);
    tick();

    // reset mid-stall
    drive(1,210,0,2,0,0,0,1, 0,0,0,0,0);
    @(negedge clk);
    chk("rs_prod_rdy", ib_if[0].ready, 1);
    tick();
    for (int j = 0; j < 3; j++) begin
      drive(1,211,0,0,2,0,0,0, 0,0,0,0,0);
      @(negedge clk);
      chk($sformatf("rs_blk c%0d", j), ib_if[0].ready, 0);
      chk($sformatf("rs_held c%0d", j), sb_if[0].uuid, 210);
      tick();
    end
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    drive(1,212,0,0,2,0,0,0, 1,0,0,0,0);
    @(negedge clk);
    chk("rs_flag", stall, 0);
    chk("rs_out_drop", sb_if[0].valid, 0);
    chk("rs_pend_clr", ib_if[0].ready, 1);
    tick();
    idle();
    @(negedge clk);
    chk("rs_new_valid", sb_if[0].valid, 1);
    chk("rs_new_uuid", sb_if[0].uuid, 212);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
